// File: rtl/serializer_n_to_1_lanes.sv
// Multi-lane N:1 serializer: one valid/ready word per lane set, shifted out one bit per clock on every lane.
// Underruns insert IDLE_WORD and are counted; dropping enable finishes the current word before going idle.
module serializer_n_to_1_lanes #(
    parameter int          DATA_WIDTH = 10,
    parameter int          LANES      = 3,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter logic [31:0] IDLE_WORD  = 32'b1101010100,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                          serial_clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   s_data,
    output logic [LANES-1:0]              serial_data_out,
    output logic                          word_start,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          underrun_cnt
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] IDLE_W = IDLE_WORD[DATA_WIDTH-1:0];

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                               state;
    logic [BIT_CNT_W-1:0]                 cnt;
    logic [LANES*DATA_WIDTH-1:0]          hold;
    logic                                 hold_valid;
    logic [LANES-1:0][DATA_WIDTH-1:0]     shifter;

    logic boundary;
    logic word_edge;
    logic load_from_hold;
    logic accept;

    // A new word enters the shifters either on start-up or on a running word boundary.
    assign boundary       = (state == RUN) && (cnt == LAST_BIT);
    assign word_edge      = ((state == IDLE) && enable) || (boundary && enable);
    assign load_from_hold = word_edge && hold_valid;
    assign s_ready        = !hold_valid || load_from_hold;
    assign accept         = s_valid && s_ready;
    assign word_start     = busy && (cnt == '0);

    always_comb begin
        serial_data_out = '0;
        for (int k = 0; k < LANES; k++) begin
            serial_data_out[k] = MSB_FIRST ? shifter[k][DATA_WIDTH-1] : shifter[k][0];
        end
    end

    always_ff @(posedge serial_clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            cnt          <= '0;
            shifter      <= '0;
            hold         <= '0;
            hold_valid   <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            // Accepting and draining on the same edge keeps hold full for back-to-back words.
            if (accept) begin
                hold       <= s_data;
                hold_valid <= 1'b1;
            end else if (load_from_hold) begin
                hold_valid <= 1'b0;
            end

            if (state == IDLE) begin
                cnt <= '0;
                if (enable) begin
                    state   <= RUN;
                    busy    <= 1'b1;
                    shifter <= hold_valid ? hold : {LANES{IDLE_W}};
                end
            end else if (!boundary) begin
                cnt <= cnt + 1'b1;
                for (int k = 0; k < LANES; k++) begin
                    shifter[k] <= MSB_FIRST ? {shifter[k][DATA_WIDTH-2:0], 1'b0}
                                            : {1'b0, shifter[k][DATA_WIDTH-1:1]};
                end
            end else begin
                cnt <= '0;
                if (!enable) begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    shifter <= '0;
                end else if (hold_valid) begin
                    shifter <= hold;
                end else begin
                    shifter <= {LANES{IDLE_W}};
                    if (underrun_cnt != '1) begin
                        underrun_cnt <= underrun_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule
